// File: rtl/traffic_b_request_gen.sv
// traffic_b_request_gen: lane-B vehicle-detect front end.
// Synchronises and debounces the loop sensor and holds the traffic_B request
// until lane B is served. It also counts arrivals and flags illegal lane-B
// light combinations.
// Optional feature macro: TRAFFIC_REQ_STUCK_EN. When it is defined, a sensor
// that reports presence for STUCK_CYCLES cycles is flagged and the request is
// dropped.
module traffic_b_request_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int STUCK_CYCLES    = 200
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             loop_sensor_raw,
    input  logic             red_light_B,
    input  logic             amber_light_B,
    input  logic             green_light_B,
    output logic             traffic_B,
    output logic             presence,
    output logic [CNT_W-1:0] detect_count,
    output logic             lights_err,
    output logic             sensor_stuck
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || CNT_W < 1 || STUCK_CYCLES < 1) begin : g_bad_params
        $error("traffic_b_request_gen: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [DB_W-1:0]        db_cnt;
    logic                   db_flip;
    logic                   arrival;
    logic [1:0]             lit_sum;
    logic [1:0]             state;
    logic [1:0]             next_state;
    logic                   force_idle;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign db_flip = (synced != presence) && (db_cnt == DB_LAST);
    assign arrival = db_flip && !presence;
    assign lit_sum = 2'(red_light_B) + 2'(amber_light_B) + 2'(green_light_B);

    // Shift the asynchronous sensor through the synchroniser chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], loop_sensor_raw};
    end

    // Change the debounced level only after DEBOUNCE_CYCLES disagreeing samples in a row
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_cnt   <= '0;
            presence <= 1'b0;
        end else if (synced == presence) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            db_cnt   <= '0;
            presence <= ~presence;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Saturating count of debounced vehicle arrivals
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            detect_count <= '0;
        else if (arrival && (detect_count != {CNT_W{1'b1}}))
            detect_count <= detect_count + CNT_W'(1);
    end

    // Sticky flag for more than one lane-B light lit at once (all-dark is legal)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                lights_err <= 1'b0;
        else if (lit_sum > 2'd1)  lights_err <= 1'b1;
    end

`ifdef TRAFFIC_REQ_STUCK_EN
    localparam int ST_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STUCK_CYCLES - 1);

    logic [ST_W-1:0] stuck_cnt;
    logic            stuck_hit;

    assign stuck_hit  = presence && !sensor_stuck && (stuck_cnt == ST_LAST);
    assign force_idle = sensor_stuck || stuck_hit;

    // Time continuous presence; flag the sensor as stuck once the limit is hit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stuck_cnt    <= '0;
            sensor_stuck <= 1'b0;
        end else if (!presence) begin
            stuck_cnt    <= '0;
            sensor_stuck <= 1'b0;
        end else if (stuck_hit) begin
            sensor_stuck <= 1'b1;
        end else if (!sensor_stuck) begin
            stuck_cnt <= stuck_cnt + ST_W'(1);
        end
    end
`else
    assign force_idle   = 1'b0;
    assign sensor_stuck = 1'b0;
`endif

    // Request/grant next-state decision; demand stays latched until lane B is served
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (presence) next_state = green_light_B ? SERVE : REQ;
            end
            REQ: begin
                if (green_light_B) next_state = SERVE;
            end
            SERVE: begin
                if (!green_light_B) next_state = presence ? REQ : IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (force_idle) next_state = IDLE;
    end

    // Register the state and derive traffic_B from the state being entered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            traffic_B <= 1'b0;
        end else begin
            state     <= next_state;
            traffic_B <= (next_state == REQ) || ((next_state == SERVE) && presence);
        end
    end

endmodule
